// File: rtl/ioctl_fifo_loader_if.sv
// ioctl_fifo_loader_if: host download strobes, memory write handshake and loader status
interface ioctl_fifo_loader_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [7:0]  ioctl_index;
  logic        ioctl_wait;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic [7:0]  mem_index;
  logic        mem_ack;
  logic        busy;
  logic        done;
  logic        overflow;
  logic        range_err;
  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, mem_ack,
    output ioctl_wait, mem_req, mem_addr, mem_data, mem_index, busy, done, overflow, range_err
  );
  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, mem_ack,
    input  ioctl_wait, mem_req, mem_addr, mem_data, mem_index, busy, done, overflow, range_err
  );
endinterface

// File: rtl/ioctl_fifo_loader.sv
// ioctl_fifo_loader: buffers host ioctl download bytes in a FIFO and replays them as memory write requests
module ioctl_fifo_loader #(
  parameter int DEPTH      = 16,
  parameter int HIGH_WATER = 12
) (
  input logic           clk_sys,
  input logic           reset_osd,
  ioctl_fifo_loader_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] HW   = (AW+1)'(HIGH_WATER);
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
  state_t state, state_nxt;
  logic [23:0]   fifo [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic          start, in_range, full, push, pop, issue, req, wait_r, ovf, rerr;
  logic [15:0]   addr;
  logic [7:0]    data, index;
  assign start    = state == IDLE && bus.ioctl_download;
  assign in_range = bus.ioctl_addr[24:16] == 9'd0;
  assign full     = count == FULL;
  assign pop      = req && bus.mem_ack;
  assign push     = state == LOAD && bus.ioctl_wr && in_range && (!full || pop);
  assign issue    = !req && count != '0 && (state == LOAD || state == DRAIN);
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    state_nxt = state == IDLE  ? (bus.ioctl_download ? LOAD : IDLE) :
                state == LOAD  ? (bus.ioctl_download ? LOAD : DRAIN) :
                state == DRAIN ? ((count == '0 && !req) ? DONE : DRAIN) : IDLE;
    count_nxt = start ? '0 : count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end
  always_ff @(posedge clk_sys or negedge reset_osd)
    if (!reset_osd) begin
      state  <= IDLE;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      req    <= 1'b0;
      addr   <= '0;
      data   <= '0;
      index  <= '0;
      wait_r <= 1'b0;
      ovf    <= 1'b0;
      rerr   <= 1'b0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      wr_ptr <= start ? '0 : wr_ptr + AW'(push);
      rd_ptr <= start ? '0 : rd_ptr + AW'(pop);
      req    <= req ? !bus.mem_ack : issue;
      addr   <= issue ? fifo[rd_ptr][23:8] : addr;
      data   <= issue ? fifo[rd_ptr][7:0] : data;
      index  <= start ? bus.ioctl_index : index;
      ovf    <= !start && (ovf || (state == LOAD && bus.ioctl_wr && in_range && full && !pop));
      rerr   <= !start && (rerr || (state == LOAD && bus.ioctl_wr && !in_range));
      wait_r <= state_nxt == DRAIN || state_nxt == DONE || (state_nxt == LOAD && count_nxt >= HW);
    end
  // A pop that coincides with a push into a full FIFO frees the slot being overwritten;
  // its contents were already captured into addr/data when the request was issued.
  always_ff @(posedge clk_sys)
    if (push) fifo[wr_ptr] <= {bus.ioctl_addr[15:0], bus.ioctl_dout};
  assign bus.ioctl_wait = wait_r;
  assign bus.mem_req    = req;
  assign bus.mem_addr   = addr;
  assign bus.mem_data   = data;
  assign bus.mem_index  = index;
  assign bus.busy       = state != IDLE;
  assign bus.done       = state == DONE;
  assign bus.overflow   = ovf;
  assign bus.range_err  = rerr;
endmodule

// File: tb/tb_ioctl_fifo_loader.sv
// tb_ioctl_fifo_loader: directed and random downloads checked against a queue-based model every cycle
module tb_ioctl_fifo_loader;
  localparam int DEPTH = 16, HW = 12;
  localparam int P_IDLE = 0, P_LOAD = 1, P_DRAIN = 2, P_DONE = 3;
  logic clk_sys = 1'b0, reset_osd = 1'b0;
  ioctl_fifo_loader_if bus();
  ioctl_fifo_loader #(.DEPTH(DEPTH), .HIGH_WATER(HW)) dut (
    .clk_sys(clk_sys), .reset_osd(reset_osd), .bus(bus)
  );
  always #5 clk_sys = ~clk_sys;
  int checks = 0, errors = 0, done_cnt = 0, ack_mode = 0, held = 0;
  logic manual_ack = 1'b0;
  logic [23:0] m_q[$], deliv[$];
  int m_ph = P_IDLE;
  logic m_ovf = 1'b0, m_rerr = 1'b0, m_wait = 1'b0, prev_req = 1'b0, prev_pop = 1'b0, pop, drained;
  logic [7:0] m_index = 8'd0;
  logic [23:0] prev_ad = 24'd0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask
  task automatic wb(input logic [24:0] a, input logic [7:0] d);
    bus.ioctl_wr = 1'b1;
    bus.ioctl_addr = a;
    bus.ioctl_dout = d;
    step();
    bus.ioctl_wr = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 1000) begin
      step();
      n++;
    end
    check("drain_timeout", 32'(bus.busy), 32'd0);
  endtask
  // Memory side: 0 never acks, 1 random acks (also while idle), 2 acks 2 cycles after each request, 3 manual
  always @(posedge clk_sys) begin
    #2;
    held = bus.mem_req ? held + 1 : 0;
    bus.mem_ack = ack_mode == 1 ? ($urandom_range(0, 2) == 0) :
                  ack_mode == 2 ? (held == 3) :
                  ack_mode == 3 ? manual_ack : 1'b0;
  end
  always @(negedge clk_sys) begin
    if (!reset_osd) begin
      check("rst_req", 32'(bus.mem_req), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_wait", 32'(bus.ioctl_wait), 32'd0);
      check("rst_flags", 32'({bus.overflow, bus.range_err}), 32'd0);
      check("rst_bus", {bus.mem_addr, bus.mem_data, bus.mem_index}, 32'd0);
      m_q.delete();
      m_ph = P_IDLE; m_ovf = 1'b0; m_rerr = 1'b0; m_wait = 1'b0; m_index = 8'd0;
      prev_req = 1'b0; prev_pop = 1'b0;
    end else begin
      check("busy", 32'(bus.busy), 32'(m_ph != P_IDLE));
      check("done", 32'(bus.done), 32'(m_ph == P_DONE));
      check("ioctl_wait", 32'(bus.ioctl_wait), 32'(m_wait));
      check("overflow", 32'(bus.overflow), 32'(m_ovf));
      check("range_err", 32'(bus.range_err), 32'(m_rerr));
      check("mem_index", 32'(bus.mem_index), 32'(m_index));
      if (prev_pop) check("req_gap", 32'(bus.mem_req), 32'd0);
      if (bus.mem_req && !prev_req) begin
        check("req_pending", 32'(m_q.size() != 0), 32'd1);
        if (m_q.size() != 0) check("req_entry", 32'({bus.mem_addr, bus.mem_data}), 32'(m_q[0]));
      end
      if (bus.mem_req && prev_req) check("req_hold", 32'({bus.mem_addr, bus.mem_data}), 32'(prev_ad));
      pop = bus.mem_req && bus.mem_ack && m_q.size() != 0;
      drained = !bus.mem_req && m_q.size() == 0;
      prev_req = bus.mem_req;
      prev_pop = bus.mem_req && bus.mem_ack;
      prev_ad = {bus.mem_addr, bus.mem_data};
      if (bus.done) done_cnt++;
      if (pop) deliv.push_back(m_q.pop_front());
      case (m_ph)
        P_IDLE: if (bus.ioctl_download) begin
          m_q.delete(); m_ovf = 1'b0; m_rerr = 1'b0; m_index = bus.ioctl_index; m_ph = P_LOAD;
        end
        P_LOAD: begin
          if (bus.ioctl_wr) begin
            if (bus.ioctl_addr[24:16] != 9'd0) m_rerr = 1'b1;
            else if (m_q.size() < DEPTH) m_q.push_back({bus.ioctl_addr[15:0], bus.ioctl_dout});
            else m_ovf = 1'b1;
          end
          if (!bus.ioctl_download) m_ph = P_DRAIN;
        end
        P_DRAIN: if (drained) m_ph = P_DONE;
        default: m_ph = P_IDLE;
      endcase
      m_wait = m_ph >= P_DRAIN || (m_ph == P_LOAD && m_q.size() >= HW);
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end
  initial begin
    int base, dc, n;
    bus.ioctl_download = 1'b0; bus.ioctl_wr = 1'b0; bus.ioctl_addr = '0;
    bus.ioctl_dout = '0; bus.ioctl_index = '0;
    step(); step();
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_req", 32'(bus.mem_req), 32'd0);
    check("reset_index", 32'(bus.mem_index), 32'd0);
    reset_osd = 1'b1;
    step();
    // Four-byte download, acks two cycles after each request
    ack_mode = 2; base = deliv.size(); dc = done_cnt;
    bus.ioctl_index = 8'h01; bus.ioctl_download = 1'b1; step();
    for (int i = 0; i < 4; i++) wb(25'(i), 8'(8'h11 + i));
    bus.ioctl_download = 1'b0;
    wait_idle();
    check("s1_count", 32'(deliv.size() - base), 32'd4);
    for (int i = 0; i < 4; i++) check("s1_byte", 32'(deliv[base + i]), 32'({16'(i), 8'(8'h11 + i)}));
    check("s1_index", 32'(bus.mem_index), 32'h01);
    check("s1_done", 32'(done_cnt - dc), 32'd1);
    check("s1_ovf", 32'(bus.overflow), 32'd0);
    // 20 back-to-back bytes with no acks: stall after 12, drop 17..20
    ack_mode = 0; base = deliv.size();
    bus.ioctl_download = 1'b1; step();
    for (int k = 0; k < 20; k++) begin
      wb(25'(k), 8'(8'hA0 + k));
      check("s2_wait", 32'(bus.ioctl_wait), 32'(k + 1 >= 12));
    end
    check("s2_ovf", 32'(bus.overflow), 32'd1);
    bus.ioctl_download = 1'b0; ack_mode = 1;
    wait_idle();
    check("s2_count", 32'(deliv.size() - base), 32'd16);
    for (int k = 0; k < 16; k++) check("s2_byte", 32'(deliv[base + k]), 32'({16'(k), 8'(8'hA0 + k)}));
    // Out-of-range address is dropped and flagged until the next download start
    base = deliv.size();
    bus.ioctl_download = 1'b1; step();
    wb(25'h010000, 8'h55);
    wb(25'h000005, 8'h66);
    check("s3_rerr", 32'(bus.range_err), 32'd1);
    bus.ioctl_download = 1'b0;
    wait_idle();
    check("s3_rerr_hold", 32'(bus.range_err), 32'd1);
    check("s3_count", 32'(deliv.size() - base), 32'd1);
    check("s3_byte", 32'(deliv[base]), 32'h000566);
    bus.ioctl_download = 1'b1; step();
    check("s3_rerr_clear", 32'(bus.range_err), 32'd0);
    bus.ioctl_download = 1'b0;
    wait_idle();
    // Full FIFO with simultaneous push and ack keeps occupancy at 16
    ack_mode = 3; manual_ack = 1'b0; base = deliv.size();
    bus.ioctl_download = 1'b1; step();
    for (int k = 0; k < 16; k++) wb(25'(k), 8'(8'hC0 + k));
    step();
    check("s4_req", 32'(bus.mem_req), 32'd1);
    manual_ack = 1'b1;
    wb(25'd16, 8'hEE);
    manual_ack = 1'b0;
    check("s4_ovf_pushpop", 32'(bus.overflow), 32'd0);
    wb(25'd17, 8'hEF);
    check("s4_still_full", 32'(bus.overflow), 32'd1);
    bus.ioctl_download = 1'b0; ack_mode = 1;
    wait_idle();
    check("s4_count", 32'(deliv.size() - base), 32'd17);
    check("s4_first", 32'(deliv[base]), 32'h0000C0);
    check("s4_last", 32'(deliv[base + 16]), 32'h0010EE);
    // Download ends with 5 queued: busy and stalled until drained
    ack_mode = 0; base = deliv.size(); dc = done_cnt;
    bus.ioctl_download = 1'b1; step();
    for (int k = 0; k < 5; k++) wb(25'(k), 8'(8'h30 + k));
    bus.ioctl_download = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("s5_busy", 32'(bus.busy), 32'd1);
      check("s5_wait", 32'(bus.ioctl_wait), 32'd1);
    end
    ack_mode = 1;
    wait_idle();
    check("s5_done", 32'(done_cnt - dc), 32'd1);
    check("s5_count", 32'(deliv.size() - base), 32'd5);
    check("s5_wait_idle", 32'(bus.ioctl_wait), 32'd0);
    // Asynchronous reset mid-drain discards queue and request
    ack_mode = 0; base = deliv.size();
    bus.ioctl_download = 1'b1; step();
    for (int k = 0; k < 3; k++) wb(25'(k), 8'(8'h70 + k));
    bus.ioctl_download = 1'b0;
    step(); step();
    check("s6_req_before", 32'(bus.mem_req), 32'd1);
    @(posedge clk_sys);
    #3 reset_osd = 1'b0;
    #1;
    check("s6_req_async", 32'(bus.mem_req), 32'd0);
    check("s6_busy_async", 32'(bus.busy), 32'd0);
    ack_mode = 1; bus.ioctl_download = 1'b1;
    step(); step();
    reset_osd = 1'b1;
    step();
    check("s6_load_first_edge", 32'(bus.busy), 32'd1);
    bus.ioctl_download = 1'b0;
    wait_idle();
    check("s6_no_writes", 32'(deliv.size() - base), 32'd0);
    // Random downloads with random acks, out-of-range bytes and stray strobes
    for (int d = 0; d < 8; d++) begin
      bus.ioctl_index = 8'($urandom); bus.ioctl_download = 1'b1; step();
      n = $urandom_range(5, 50);
      for (int i = 0; i < n; i++) begin
        bus.ioctl_wr = ($urandom_range(0, 3) != 0) && (!bus.ioctl_wait || $urandom_range(0, 2) == 0);
        bus.ioctl_addr = ($urandom_range(0, 11) == 0) ? {9'($urandom_range(1, 511)), 16'($urandom)}
                                                      : {9'd0, 16'($urandom)};
        bus.ioctl_dout = 8'($urandom);
        step();
      end
      bus.ioctl_download = 1'b0;
      for (int i = 0; i < 3; i++) begin
        bus.ioctl_wr = 1'($urandom);
        step();
      end
      bus.ioctl_wr = 1'b0;
      wait_idle();
      bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'h1FF0000;
      step();
      bus.ioctl_wr = 1'b0;
    end
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ioctl_fifo_loader.md
IOCTL_FIFO_LOADER -- requirements
Module: ioctl_fifo_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, >= 8).
REQ-002 SHALL have parameter HIGH_WATER, default 12, occupancy at or above which the host is stalled.
REQ-003 SHALL have port clk_sys  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_osd  input  1  reset; the reset is asynchronous and active-low.
REQ-005 SHALL have port ioctl_download  input  1  host download window active (level).
REQ-006 SHALL have port ioctl_wr  input  1  host byte strobe, one byte per clk_sys cycle high.
REQ-007 SHALL have port ioctl_addr  input  25  host byte address.
REQ-008 SHALL have port ioctl_dout  input  8  host byte data.
REQ-009 SHALL have port ioctl_index  input  8  host file/ROM index.
REQ-010 SHALL have port ioctl_wait  output  1  stall request to host, registered.
REQ-011 SHALL have port mem_req  output  1  write request to the lynx48 memory side.
REQ-012 SHALL have port mem_addr  output  16  write address.
REQ-013 SHALL have port mem_data  output  8  write data.
REQ-014 SHALL have port mem_index  output  8  index latched at download start.
REQ-015 SHALL have port mem_ack  input  1  one-cycle acceptance pulse from the memory side.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-017 SHALL have port done  output  1  one-cycle pulse when a download has fully drained.
REQ-018 SHALL have port overflow  output  1  sticky: a byte was dropped because the FIFO was full.
REQ-019 SHALL have port range_err  output  1  sticky: a byte was dropped because ioctl_addr[24:16] was nonzero.

Function
REQ-020 SHALL implement states IDLE, LOAD, DRAIN, DONE.
REQ-021 IDLE->LOAD SHALL occur when ioctl_download=1; on that transition, mem_index<=ioctl_index, the FIFO is emptied, and overflow and range_err are cleared.
REQ-022 LOAD->DRAIN SHALL occur when ioctl_download=0.
REQ-023 DRAIN->DONE SHALL occur when the FIFO is empty and mem_req=0; DONE SHALL last exactly one cycle with done=1, then go to IDLE.
REQ-024 In LOAD, ioctl_wr=1 with ioctl_addr[24:16]=0 and FIFO not full SHALL push {ioctl_addr[15:0], ioctl_dout} in that cycle.
REQ-025 ioctl_wr=1 with ioctl_addr[24:16]!=0 SHALL drop the byte and set range_err.
REQ-026 ioctl_wr=1 with the FIFO full SHALL drop the byte and set overflow.
REQ-027 ioctl_wr outside LOAD SHALL be ignored with no flag change.
REQ-028 Occupancy count SHALL be DEPTH-bit-safe (0..DEPTH); read/write pointers SHALL wrap modulo DEPTH.
REQ-029 A push and a pop in the same cycle SHALL leave the count unchanged, including when the FIFO is full.
REQ-030 mem_req SHALL rise no earlier than the cycle after the push of its entry; mem_addr and mem_data SHALL be held stable while mem_req=1.
REQ-031 mem_ack while mem_req=1 SHALL pop the entry; mem_req SHALL drop in the next cycle and SHALL re-assert no earlier than one cycle later if entries remain.
REQ-032 mem_ack while mem_req=0 SHALL be ignored.
REQ-033 ioctl_wait SHALL be 1 in the cycle after count>=HIGH_WATER in LOAD, and SHALL be 1 throughout DRAIN and DONE; otherwise it SHALL be 0.
REQ-034 Bytes SHALL be delivered to memory in push order with no duplication.

Reset
REQ-035 While reset_osd=0, the block SHALL immediately, asynchronously, reach state IDLE with FIFO empty, and ioctl_wait, mem_req, busy, done, overflow and range_err all 0, and mem_addr, mem_data and mem_index all 0.
REQ-036 Reset asserted mid-LOAD or mid-DRAIN SHALL discard all queued bytes and any outstanding request.
REQ-037 After reset_osd rises, with ioctl_download=1, the block SHALL enter LOAD on the first clock edge.

Verification
REQ-038 Download of 4 bytes 0x11..0x14 at addresses 0x0000..0x0003 with index 0x01, mem_ack returned 2 cycles after each mem_req -> 4 writes in order; mem_index=0x01; one done pulse; overflow=0.
REQ-039 Push 20 bytes back-to-back with mem_ack held 0 (DEPTH=16, HIGH_WATER=12) -> ioctl_wait=1 from the cycle after the 12th push; bytes 17..20 are dropped; overflow=1; the first 16 bytes are later delivered intact.
REQ-040 Push one byte at ioctl_addr=0x010000 -> no mem_req for it; range_err=1; the flag is cleared at the next download start.
REQ-041 FIFO full, then simultaneous push and mem_ack -> count stays 16; overflow stays 0; the new byte appears last.
REQ-042 ioctl_download falls with 5 entries queued -> busy=1 and ioctl_wait=1 until drained; done pulses once; then IDLE.
REQ-043 Assert reset_osd=0 mid-DRAIN with 3 entries queued -> mem_req=0 and busy=0 with no clock edge; no further writes are issued after release.
